pmu_csr: RTL and testbench

- Responder side of the CPU CSR sub-unit interface for the performance-monitor address space.
- Accepts the PMU write strobe and address from the CSR decoder and returns PMU read data to it.
- Holds the cycle, instret and hardware-performance counters, the counter inhibit register, and the read-only machine ID registers.
- Sits beside the FPU, debug, MPU and SRU CSR responders inside the CPU core.

---
 rtl/pmu_csr_pkg.sv | 46 ++++
 rtl/pmu_csr_if.sv | 15 +
 rtl/pmu_cnt64.sv | 48 ++++
 rtl/pmu_csr.sv | 146 ++++++++++++++
 tb/tb_pmu_csr.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmu_csr_pkg.sv
// Shared CPU definitions for the PMU CSR responder: CSR addresses, the HPM event-index
// type and small elaboration-time helpers.
package pmu_csr_pkg;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_TIMEH         = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_HPMCOUNTER3H  = 12'hC83;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  // Container for an event selector; instances keep only $clog2(EVT_NUM+1) bits of it.
  localparam int unsigned HpmEvtWMax = 8;
  typedef logic [HpmEvtWMax-1:0] hpm_evt_idx_t;

  // Writable mcountinhibit bits: CY, IR and one bit per implemented HPM counter.
  function automatic logic [31:0] inhibit_mask(input int unsigned hpm_num, input bit hpm_en);
    logic [31:0] m;
    m = 32'h5;
    if (hpm_en) begin
      for (int unsigned i = 0; i < hpm_num && i < 29; i++) m[3+i] = 1'b1;
    end
    return m;
  endfunction

  // WARL legalisation of an mhpmevent write: selectors beyond the event vector become 0.
  function automatic hpm_evt_idx_t evt_sel_legal(input logic [63:0] wdata,
                                                 input int unsigned evt_num);
    return (wdata > 64'(evt_num)) ? '0 : hpm_evt_idx_t'(wdata);
  endfunction

endpackage

// File: rtl/pmu_csr_if.sv
// CSR decoder <-> PMU responder bus: shared address, write strobe/data, read data.
interface pmu_csr_if #(
  parameter int unsigned XLEN = 32
);
  import pmu_csr_pkg::*;

  logic [11:0]     addr;
  logic            wr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;

  modport master (output addr, wr, wdata, input rdata);
  modport slave  (input addr, wr, wdata, output rdata);

endinterface

// File: rtl/pmu_cnt64.sv
// 64-bit event counter. A write to either half suppresses the increment for that cycle, so
// the untouched half holds its pre-increment value. With XLEN=64 either strobe writes all 64.
module pmu_cnt64
  import pmu_csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_we_lo,
  input  logic            i_we_hi,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_inc,
  output logic [63:0]     o_cnt
);

  logic [63:0] r_cnt;
  logic [63:0] w_cnt_d;
  logic [63:0] w_wmask;
  logic [63:0] w_wval;

  if (XLEN == 64) begin : g_x64
    assign w_wval  = 64'(i_wdata);
    assign w_wmask = (i_we_lo || i_we_hi) ? '1 : '0;
  end else begin : g_x32
    assign w_wval  = {2{i_wdata[31:0]}};
    assign w_wmask = {{32{i_we_hi}}, {32{i_we_lo}}};
  end

  // Next count: write has priority over increment; wrap is modulo 2^64.
  always_comb begin
    w_cnt_d = r_cnt;
    if (|w_wmask) begin
      w_cnt_d = (r_cnt & ~w_wmask) | (w_wval & w_wmask);
    end else if (i_inc) begin
      w_cnt_d = r_cnt + 64'd1;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cnt <= '0;
    else       r_cnt <= w_cnt_d;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pmu_csr.sv
// PMU CSR responder: mcycle/minstret/mhpmcounter, mcountinhibit, mhpmevent, time shadow
// and machine ID registers. Optional macro PMU_HPM_EN implements the HPM counter pairs;
// without it those addresses read 0 and no HPM flops exist.
module pmu_csr
  import pmu_csr_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned HPM_NUM   = 4,
  parameter int unsigned EVT_NUM   = 16,
  parameter logic [31:0] MVENDORID = '0,
  parameter logic [31:0] MARCHID   = '0,
  parameter logic [31:0] MIMPID    = '0
) (
  input  logic               clk,
  input  logic               rstn,
  pmu_csr_if.slave           bus,
  input  logic               inst_ret,
  input  logic [EVT_NUM-1:0] hpm_event,
  input  logic               stop_cnt,
  input  logic [63:0]        mtime,
  input  logic [XLEN-1:0]    hartid
);

`ifdef PMU_HPM_EN
  localparam bit HpmEn = 1'b1;
`else
  localparam bit HpmEn = 1'b0;
`endif
  localparam logic [31:0] InhMask = inhibit_mask(HPM_NUM, HpmEn);
  localparam bit          Rv32    = (XLEN == 32);

  logic [31:0]     r_inh;
  logic            w_run;
  logic [63:0]     w_mcycle;
  logic [63:0]     w_minstret;
  logic [XLEN-1:0] w_rdata;

  assign w_run = !stop_cnt;

  // mcountinhibit; the new value gates increments from the following cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inh <= '0;
    end else if (bus.wr && bus.addr == CSR_MCOUNTINHIBIT) begin
      r_inh <= bus.wdata[31:0] & InhMask;
    end
  end

  pmu_cnt64 #(.XLEN(XLEN)) u_mcycle (
    .clk     (clk),
    .rstn    (rstn),
    .i_we_lo (bus.wr && bus.addr == CSR_MCYCLE),
    .i_we_hi (Rv32 && bus.wr && bus.addr == CSR_MCYCLEH),
    .i_wdata (bus.wdata),
    .i_inc   (w_run && !r_inh[0]),
    .o_cnt   (w_mcycle)
  );

  pmu_cnt64 #(.XLEN(XLEN)) u_minstret (
    .clk     (clk),
    .rstn    (rstn),
    .i_we_lo (bus.wr && bus.addr == CSR_MINSTRET),
    .i_we_hi (Rv32 && bus.wr && bus.addr == CSR_MINSTRETH),
    .i_wdata (bus.wdata),
    .i_inc   (w_run && inst_ret && !r_inh[2]),
    .o_cnt   (w_minstret)
  );

`ifdef PMU_HPM_EN
  localparam int unsigned EW = $clog2(EVT_NUM + 1);

  logic [63:0]   w_hpm_cnt [HPM_NUM];
  logic [EW-1:0] w_evt_sel [HPM_NUM];
  logic [EVT_NUM:0] w_evt_ext;

  // Selector 0 picks the constant-0 slot, k picks hpm_event[k-1].
  assign w_evt_ext = {hpm_event, 1'b0};

  for (genvar gi = 0; gi < HPM_NUM; gi++) begin : g_hpm
    logic [EW-1:0] r_evt;

    // mhpmevent selector, WARL-legalised on write.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_evt <= '0;
      end else if (bus.wr && bus.addr == CSR_MHPMEVENT3 + 12'(gi)) begin
        r_evt <= EW'(evt_sel_legal(64'(bus.wdata), EVT_NUM));
      end
    end

    assign w_evt_sel[gi] = r_evt;

    pmu_cnt64 #(.XLEN(XLEN)) u_cnt (
      .clk     (clk),
      .rstn    (rstn),
      .i_we_lo (bus.wr && bus.addr == CSR_MHPMCOUNTER3 + 12'(gi)),
      .i_we_hi (Rv32 && bus.wr && bus.addr == CSR_MHPMCOUNTER3H + 12'(gi)),
      .i_wdata (bus.wdata),
      .i_inc   (w_run && !r_inh[3+gi] && w_evt_ext[r_evt]),
      .o_cnt   (w_hpm_cnt[gi])
    );
  end
`else
  logic w_unused_hpm_event;
  assign w_unused_hpm_event = ^hpm_event;
`endif

  // Zero-latency read mux; unknown addresses read 0.
  always_comb begin
    w_rdata = '0;
    case (bus.addr)
      CSR_MCOUNTINHIBIT:         w_rdata = XLEN'(r_inh);
      CSR_MCYCLE, CSR_CYCLE:     w_rdata = w_mcycle[XLEN-1:0];
      CSR_MINSTRET, CSR_INSTRET: w_rdata = w_minstret[XLEN-1:0];
      CSR_TIME:                  w_rdata = mtime[XLEN-1:0];
      CSR_MVENDORID:             w_rdata = XLEN'(MVENDORID);
      CSR_MARCHID:               w_rdata = XLEN'(MARCHID);
      CSR_MIMPID:                w_rdata = XLEN'(MIMPID);
      CSR_MHARTID:               w_rdata = hartid;
      default: ;
    endcase
    if (Rv32) begin
      case (bus.addr)
        CSR_MCYCLEH, CSR_CYCLEH:     w_rdata = XLEN'(w_mcycle >> 32);
        CSR_MINSTRETH, CSR_INSTRETH: w_rdata = XLEN'(w_minstret >> 32);
        CSR_TIMEH:                   w_rdata = XLEN'(mtime >> 32);
        default: ;
      endcase
    end
`ifdef PMU_HPM_EN
    for (int i = 0; i < HPM_NUM; i++) begin
      if (bus.addr == CSR_MHPMEVENT3 + 12'(i)) w_rdata = XLEN'(w_evt_sel[i]);
      if (bus.addr == CSR_MHPMCOUNTER3 + 12'(i) || bus.addr == CSR_HPMCOUNTER3 + 12'(i)) begin
        w_rdata = w_hpm_cnt[i][XLEN-1:0];
      end
      if (Rv32 && (bus.addr == CSR_MHPMCOUNTER3H + 12'(i) ||
                   bus.addr == CSR_HPMCOUNTER3H + 12'(i))) begin
        w_rdata = XLEN'(w_hpm_cnt[i] >> 32);
      end
    end
`endif
  end

  assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_pmu_csr.sv
// Self-checking bench for pmu_csr (XLEN=32). The reference model treats the PMU as an array
// of 32 counter slots indexed by CSR offset n (0xB00+n / 0xB80+n / 0xC00+n / 0xC80+n).
module tb_pmu_csr;

  localparam int unsigned HpmNum = 4;
  localparam int unsigned EvtNum = 16;
`ifdef PMU_HPM_EN
  localparam bit HpmEn = 1'b1;
`else
  localparam bit HpmEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              inst_ret = 1'b0;
  logic [EvtNum-1:0] hpm_event = '0;
  logic              stop_cnt = 1'b0;
  logic [63:0]       mtime = 64'h0000_0007_0000_0042;
  logic [31:0]       hartid = 32'hC0DE_0002;

  pmu_csr_if #(.XLEN(32)) bus ();

  pmu_csr #(
    .XLEN      (32),
    .HPM_NUM   (HpmNum),
    .EVT_NUM   (EvtNum),
    .MVENDORID (32'h0000_1234),
    .MARCHID   (32'h0000_0005),
    .MIMPID    (32'h0000_0077)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .inst_ret  (inst_ret),
    .hpm_event (hpm_event),
    .stop_cnt  (stop_cnt),
    .mtime     (mtime),
    .hartid    (hartid)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state.
  logic [63:0] m_cnt [32];
  int          m_evt [32];
  logic [31:0] m_inh;
  logic [31:0] m_mask;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit impl(input int n);
    return n == 0 || n == 2 || (HpmEn && n >= 3 && n < 3 + int'(HpmNum));
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 32; k++) begin
      m_cnt[k] = '0;
      m_evt[k] = 0;
    end
    m_inh = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int n;
    n = int'(a[4:0]);
    if (a == 12'h320) return m_inh;
    if (a[11:5] == 7'h19 && n >= 3) return impl(n) ? 32'(m_evt[n]) : 32'h0;
    if (a[11:5] == 7'h58) return impl(n) ? m_cnt[n][31:0] : 32'h0;
    if (a[11:5] == 7'h5C) return impl(n) ? m_cnt[n][63:32] : 32'h0;
    if (a[11:5] == 7'h60) return (n == 1) ? mtime[31:0] : impl(n) ? m_cnt[n][31:0] : 32'h0;
    if (a[11:5] == 7'h64) return (n == 1) ? mtime[63:32] : impl(n) ? m_cnt[n][63:32] : 32'h0;
    case (a)
      12'hF11: return 32'h0000_1234;
      12'hF12: return 32'h0000_0005;
      12'hF13: return 32'h0000_0077;
      12'hF14: return hartid;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the reference, using the inputs presented for that edge.
  task automatic model_step();
    logic [63:0] nxt [32];
    logic [31:0] wd;
    bit          inc;
    int          n;
    wd = bus.wdata;
    for (int k = 0; k < 32; k++) begin
      nxt[k] = m_cnt[k];
      if (impl(k)) begin
        inc = !m_inh[k] && !stop_cnt &&
              (k == 0 || (k == 2 && inst_ret) ||
               (k >= 3 && m_evt[k] != 0 && hpm_event[m_evt[k]-1]));
        if (bus.wr && bus.addr == 12'hB00 + 12'(k))      nxt[k][31:0]  = wd;
        else if (bus.wr && bus.addr == 12'hB80 + 12'(k)) nxt[k][63:32] = wd;
        else if (inc)                                    nxt[k] = m_cnt[k] + 64'd1;
      end
    end
    n = int'(bus.addr[4:0]);
    if (bus.wr && bus.addr[11:5] == 7'h19 && n >= 3 && impl(n)) begin
      m_evt[n] = (wd > EvtNum) ? 0 : int'(wd);
    end
    if (bus.wr && bus.addr == 12'h320) m_inh = wd & m_mask;
    for (int k = 0; k < 32; k++) m_cnt[k] = nxt[k];
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) model_step();
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.rdata;
  endtask

  task automatic chk_rd(input string tag, input logic [11:0] a);
    logic [31:0] v;
    rd(a, v);
    check_eq(tag, v, m_read(a));
  endtask

  task automatic chk_lit(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check_eq(tag, v, exp);
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr    = 1'b1;
    tick();
    bus.wr = 1'b0;
  endtask

  logic [11:0] addr_pool [26] = '{
    12'h320, 12'h321, 12'h323, 12'h324, 12'h326, 12'h327, 12'hB00, 12'hB01, 12'hB02,
    12'hB03, 12'hB06, 12'hB07, 12'hB80, 12'hB82, 12'hB83, 12'hC00, 12'hC01, 12'hC02,
    12'hC03, 12'hC80, 12'hC81, 12'hC82, 12'hC83, 12'hF11, 12'hF14, 12'h7FF
  };

  initial begin
    logic [63:0] snap_cy;
    logic [63:0] snap_ir;
    logic [11:0] a;

    m_mask = 32'h5;
    if (HpmEn) for (int i = 0; i < int'(HpmNum); i++) m_mask[3+i] = 1'b1;
    m_reset();
    bus.addr  = '0;
    bus.wr    = 1'b0;
    bus.wdata = '0;

    // Reset values.
    chk_lit("rst_mcycle", 12'hB00, 32'h0);
    chk_lit("rst_minstret", 12'hB02, 32'h0);
    chk_lit("rst_inhibit", 12'h320, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Ten idle cycles after release.
    repeat (10) tick();
    chk_lit("mcycle_10", 12'hB00, 32'd10);
    chk_lit("minstret_0", 12'hB02, 32'd0);
    chk_lit("mhartid", 12'hF14, 32'hC0DE_0002);
    chk_lit("mvendorid", 12'hF11, 32'h0000_1234);
    chk_lit("mimpid", 12'hF13, 32'h0000_0077);

    // 64-bit wrap.
    wr_csr(12'hB80, 32'hFFFF_FFFF);
    wr_csr(12'hB00, 32'hFFFF_FFFE);
    chk_lit("wrap_fe", 12'hB00, 32'hFFFF_FFFE);
    chk_lit("wrap_hi", 12'hB80, 32'hFFFF_FFFF);
    tick();
    chk_lit("wrap_ff", 12'hB00, 32'hFFFF_FFFF);
    tick();
    chk_lit("wrap_0", 12'hB00, 32'h0);
    chk_lit("wrap_hi0", 12'hB80, 32'h0);
    tick();
    chk_lit("wrap_1", 12'hB00, 32'h1);

    // High-half write on the carry edge: increment suppressed, no carry.
    wr_csr(12'hB80, 32'h0);
    wr_csr(12'hB00, 32'hFFFF_FFFF);
    wr_csr(12'hB80, 32'h5);
    chk_lit("nocarry_hi", 12'hB80, 32'h5);
    chk_rd("nocarry_lo", 12'hB00);
    tick();
    chk_rd("after_lo", 12'hB00);
    chk_rd("after_hi", 12'hB80);

    // Inhibit CY and IR.
    wr_csr(12'h320, 32'hFFFF_FFFF);
    chk_rd("inh_mask", 12'h320);
    wr_csr(12'h320, 32'h5);
    snap_cy  = m_cnt[0];
    snap_ir  = m_cnt[2];
    inst_ret = 1'b1;
    repeat (4) tick();
    inst_ret = 1'b0;
    chk_lit("inh_cy", 12'hB00, snap_cy[31:0]);
    chk_lit("inh_ir", 12'hB02, snap_ir[31:0]);
    wr_csr(12'h320, 32'h0);
    inst_ret = 1'b1;
    tick();
    tick();
    chk_rd("resume_cy", 12'hB00);
    chk_rd("resume_ir", 12'hB02);
    wr_csr(12'hB02, 32'h0000_1234);
    inst_ret = 1'b0;
    chk_lit("ir_wr_wins", 12'hB02, 32'h0000_1234);

`ifdef PMU_HPM_EN
    wr_csr(12'hB03, 32'h0);
    wr_csr(12'hB83, 32'h0);
    wr_csr(12'h323, 32'd2);
    chk_lit("evt_sel", 12'h323, 32'd2);
    repeat (7) begin
      hpm_event = 16'h0002;
      tick();
      hpm_event = '0;
      tick();
    end
    chk_lit("hpm_7", 12'hC03, 32'd7);
    wr_csr(12'h323, EvtNum + 1);
    chk_lit("evt_warl", 12'h323, 32'd0);
    hpm_event = 16'h0002;
    repeat (3) tick();
    hpm_event = '0;
    chk_lit("hpm_stop", 12'hC03, 32'd7);
`else
    wr_csr(12'h323, 32'd2);
    chk_lit("evt_absent", 12'h323, 32'd0);
`endif

    // Debug stop freezes counting; time still tracks mtime.
    snap_cy  = m_cnt[0];
    snap_ir  = m_cnt[2];
    stop_cnt = 1'b1;
    inst_ret = 1'b1;
    repeat (5) begin
      mtime = {$urandom, $urandom};
      tick();
    end
    chk_lit("stop_cy", 12'hB00, snap_cy[31:0]);
    chk_lit("stop_ir", 12'hB02, snap_ir[31:0]);
    chk_lit("time_lo", 12'hC01, mtime[31:0]);
    stop_cnt = 1'b0;
    inst_ret = 1'b0;
    chk_lit("time_hi", 12'hC81, mtime[63:32]);

    // Randomized traffic against the reference.
    for (int c = 0; c < 600; c++) begin
      a         = addr_pool[$urandom_range(0, 25)];
      bus.addr  = a;
      bus.wr    = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: bus.wdata = $urandom;
        1: bus.wdata = 32'hFFFF_FFFF - $urandom_range(0, 3);
        2: bus.wdata = $urandom_range(0, 20);
        default: bus.wdata = 32'h0;
      endcase
      inst_ret  = $urandom_range(0, 1) == 1;
      hpm_event = EvtNum'($urandom);
      stop_cnt  = ($urandom_range(0, 7) == 0);
      mtime     = mtime + 64'($urandom_range(0, 5));
      #1;
      check_eq($sformatf("rand@%h", a), bus.rdata, m_read(a));
      tick();
    end
    bus.wr    = 1'b0;
    inst_ret  = 1'b0;
    stop_cnt  = 1'b0;
    hpm_event = '0;
    wr_csr(12'h320, 32'h0);
    chk_rd("post_rand_cy", 12'hB00);
    chk_rd("post_rand_ir", 12'hB02);

    // Reset asserted during a write.
    bus.addr  = 12'hB00;
    bus.wdata = 32'h0000_0123;
    bus.wr    = 1'b1;
    #2;
    rstn = 1'b0;
    m_reset();
    chk_lit("rst_mid_wr", 12'hB00, 32'h0);
    bus.wr = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk_lit("rst_then_1", 12'hB00, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
